bus_arbiter_2m: RTL

- Two-master arbiter for the shared 8-bit microprocessor bus (BUS_ADDR / BUS_DATA / BUS_WE).
- Lets the CPU (M0) and a second master (M1, e.g. DMA or LED animation engine) share the bus in front of memory-mapped peripherals such as the LED bus interface at 0xC0–0xC1.
- Round-robin grant with a hold limit, lock, and a drain phase so in-flight reads complete before ownership changes.

---
 rtl/bus_arbiter_2m.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_2m.sv
// Two-master arbiter for the shared 8-bit peripheral bus.
// Round-robin ownership with a hold limit, an owner lock and a drain phase
// that lets the last read of an owner complete before the bus changes hands.
module bus_arbiter_2m #(
   parameter int          READ_LAT  = 1,
   parameter int          MAX_HOLD  = 16,
   parameter logic [7:0]  IDLE_ADDR = 8'hFF
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_m0_req,
   input  logic       i_m0_lock,
   input  logic [7:0] i_m0_addr,
   input  logic       i_m0_we,
   input  logic [7:0] i_m0_wdata,
   output logic       o_m0_gnt,
   output logic [7:0] o_m0_rdata,
   input  logic       i_m1_req,
   input  logic       i_m1_lock,
   input  logic [7:0] i_m1_addr,
   input  logic       i_m1_we,
   input  logic [7:0] i_m1_wdata,
   output logic       o_m1_gnt,
   output logic [7:0] o_m1_rdata,
   output logic [7:0] o_bus_addr,
   inout  wire  [7:0] io_bus_data,
   output logic       o_bus_we
);

   localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam int DW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [HW-1:0] HOLD_LAST  = HW'(MAX_HOLD - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(READ_LAT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OWN,
      ST_DRAIN
   } state_t;

   state_t          r_state;
   logic            r_owner;
   logic            r_last_owner;
   logic [HW-1:0]   r_hold_cnt;
   logic [DW-1:0]   r_drain_cnt;
   logic            r_m0_gnt;
   logic            r_m1_gnt;

   state_t          w_state_nxt;
   logic            w_owner_nxt;
   logic            w_last_nxt;
   logic [HW-1:0]   w_hold_nxt;
   logic [DW-1:0]   w_drain_nxt;

   logic            w_own_req;
   logic            w_oth_req;
   logic            w_own_lock;
   logic            w_prev_req;
   logic            w_alt_req;
   logic            w_own_we;
   logic [7:0]      w_own_addr;
   logic [7:0]      w_own_wdata;
   logic            w_bus_active;
   logic            w_drive;

   // "Owner" and "other" views of the two masters, selected by the current owner
   assign w_own_req   = r_owner ? i_m1_req   : i_m0_req;
   assign w_oth_req   = r_owner ? i_m0_req   : i_m1_req;
   assign w_own_lock  = r_owner ? i_m1_lock  : i_m0_lock;
   assign w_own_we    = r_owner ? i_m1_we    : i_m0_we;
   assign w_own_addr  = r_owner ? i_m1_addr  : i_m0_addr;
   assign w_own_wdata = r_owner ? i_m1_wdata : i_m0_wdata;

   // Requests seen relative to the master that owned the bus last
   assign w_prev_req  = r_last_owner ? i_m1_req : i_m0_req;
   assign w_alt_req   = r_last_owner ? i_m0_req : i_m1_req;

   // Bus muxing is combinational so an async reset blanks the bus instantly
   assign w_bus_active = (r_state == ST_OWN);
   assign w_drive      = w_bus_active && w_own_we;
   assign o_bus_addr   = w_bus_active ? w_own_addr : IDLE_ADDR;
   assign o_bus_we     = w_drive;
   assign io_bus_data  = w_drive ? w_own_wdata : 8'hzz;
   assign o_m0_rdata   = io_bus_data;
   assign o_m1_rdata   = io_bus_data;
   assign o_m0_gnt     = r_m0_gnt;
   assign o_m1_gnt     = r_m1_gnt;

   // Next-state logic: arbitration in IDLE, hold/lock policing in OWN, drain countdown
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last_owner;
      w_hold_nxt  = r_hold_cnt;
      w_drain_nxt = r_drain_cnt;
      case (r_state)
         ST_IDLE: begin
            w_hold_nxt = '0;
            if (i_m0_req && i_m1_req) begin
               w_state_nxt = ST_OWN;
               w_owner_nxt = ~r_last_owner;
            end else if (i_m0_req) begin
               w_state_nxt = ST_OWN;
               w_owner_nxt = 1'b0;
            end else if (i_m1_req) begin
               w_state_nxt = ST_OWN;
               w_owner_nxt = 1'b1;
            end
         end
         ST_OWN: begin
            if (!w_own_req || (w_oth_req && (r_hold_cnt == HOLD_LAST) && !w_own_lock)) begin
               w_state_nxt = ST_DRAIN;
               w_last_nxt  = r_owner;
               w_hold_nxt  = '0;
               w_drain_nxt = '0;
            end else if (r_hold_cnt != HOLD_LAST) begin
               w_hold_nxt = r_hold_cnt + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (r_drain_cnt == DRAIN_LAST) begin
               w_hold_nxt = '0;
               if (w_alt_req) begin
                  w_state_nxt = ST_OWN;
                  w_owner_nxt = ~r_last_owner;
               end else if (w_prev_req) begin
                  w_state_nxt = ST_OWN;
                  w_owner_nxt = r_last_owner;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_drain_nxt = r_drain_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered grants; M0 wins the first tie after reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b1;
         r_hold_cnt   <= '0;
         r_drain_cnt  <= '0;
         r_m0_gnt     <= 1'b0;
         r_m1_gnt     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_owner <= w_last_nxt;
         r_hold_cnt   <= w_hold_nxt;
         r_drain_cnt  <= w_drain_nxt;
         r_m0_gnt     <= (w_state_nxt == ST_OWN) && !w_owner_nxt;
         r_m1_gnt     <= (w_state_nxt == ST_OWN) &&  w_owner_nxt;
      end
   end

endmodule
